// File: rtl/bsg_manycore_block_mem_burst_arbiter.sv
// Burst-locked round-robin arbiter sharing one memory-side request port
// among the per-column block-mem links of a pod row.
module bsg_manycore_block_mem_burst_arbiter #(
  parameter int num_tiles_x_p = 4,
  parameter int data_width_p = 32,
  parameter int icache_block_size_in_words_p = 4,
  localparam int id_width_lp =
    (num_tiles_x_p > 1) ? $clog2(num_tiles_x_p) : 1,
  localparam int cnt_width_lp =
    (icache_block_size_in_words_p + 1 > 1)
      ? $clog2(icache_block_size_in_words_p + 1) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [num_tiles_x_p-1:0] req_v_i,
  input  logic [num_tiles_x_p*data_width_p-1:0] req_data_i,
  output logic [num_tiles_x_p-1:0] req_yumi_o,
  output logic v_o,
  output logic [data_width_p-1:0] data_o,
  output logic [id_width_lp-1:0] src_id_o,
  input  logic ready_i,
  output logic burst_active_o,
  output logic burst_done_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e state_r, state_n;
  logic [id_width_lp-1:0] rr_ptr_r, rr_ptr_n;
  logic [id_width_lp-1:0] owner_r, owner_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;

  logic [data_width_p-1:0] w_data [num_tiles_x_p];
  logic [id_width_lp-1:0] w_sel;
  logic w_found;
  logic w_last;
  logic w_owner_v;

  function automatic logic [id_width_lp-1:0] f_inc(
    input logic [id_width_lp-1:0] a
  );
    if (int'(a) == num_tiles_x_p - 1) return '0;
    else return a + 1'b1;
  endfunction

  for (genvar x = 0; x < num_tiles_x_p; x++) begin : g_slice
    assign w_data[x] = req_data_i[x*data_width_p +: data_width_p];
  end

  // Scan from highest offset down so the nearest valid one wins.
  always_comb begin
    int idx;
    idx = 0;
    w_sel = rr_ptr_r;
    w_found = 1'b0;
    for (int i = num_tiles_x_p - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= num_tiles_x_p) idx = idx - num_tiles_x_p;
      if (req_v_i[idx]) begin
        w_sel = id_width_lp'(idx);
        w_found = 1'b1;
      end
    end
  end

  assign w_last =
    (cnt_r == cnt_width_lp'(icache_block_size_in_words_p - 1));
  assign w_owner_v = req_v_i[owner_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
      rr_ptr_r <= '0;
      owner_r <= '0;
      cnt_r <= '0;
    end else begin
      state_r <= state_n;
      rr_ptr_r <= rr_ptr_n;
      owner_r <= owner_n;
      cnt_r <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    rr_ptr_n = rr_ptr_r;
    owner_n = owner_r;
    cnt_n = cnt_r;
    unique case (state_r)
      S_IDLE: begin
        if (w_found && ready_i) begin
          if (icache_block_size_in_words_p == 1) begin
            rr_ptr_n = f_inc(w_sel);
          end else begin
            owner_n = w_sel;
            cnt_n = cnt_width_lp'(1);
            state_n = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_owner_v && ready_i) begin
          cnt_n = cnt_r + 1'b1;
          if (w_last) begin
            cnt_n = '0;
            rr_ptr_n = f_inc(owner_r);
            state_n = S_IDLE;
          end
        end
      end
    endcase
  end

  // Everything is held quiet while reset is asserted.
  always_comb begin
    v_o = 1'b0;
    data_o = w_data[w_sel];
    src_id_o = w_sel;
    req_yumi_o = '0;
    burst_active_o = 1'b0;
    burst_done_o = 1'b0;
    if (!reset_i) begin
      unique case (state_r)
        S_IDLE: begin
          v_o = w_found;
          if (w_found && ready_i) begin
            req_yumi_o[w_sel] = 1'b1;
            if (icache_block_size_in_words_p == 1) burst_done_o = 1'b1;
          end
        end
        S_BURST: begin
          burst_active_o = 1'b1;
          v_o = w_owner_v;
          data_o = w_data[owner_r];
          src_id_o = owner_r;
          if (w_owner_v && ready_i) begin
            req_yumi_o[owner_r] = 1'b1;
            burst_done_o = w_last;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bsg_manycore_block_mem_burst_arbiter.md
Name: bsg_manycore_block_mem_burst_arbiter

Overview:
Round-robin arbiter that shares one memory-side request port among the num_tiles_x_p column block-mem links of a pod's block-mem row.
Grants are burst-locked: once a requester wins, it owns the port for exactly icache_block_size_in_words_p accepted beats, so an icache block fill is never interleaved with another column's traffic.
It sits between the per-column block-mem request outputs and the shared downstream channel (memory controller or test host).

Parameters:
num_tiles_x_p, 4, number of requesters (one per column); must be >= 1.
data_width_p, 32, width of one request beat.
icache_block_size_in_words_p, 4, beats per locked burst; must be >= 1.
localparam id_width_lp, `BSG_SAFE_CLOG2(num_tiles_x_p), width of the requester id.
localparam cnt_width_lp, `BSG_SAFE_CLOG2(icache_block_size_in_words_p+1), width of the beat counter.

Ports:
clk_i  input  1  clock.
reset_i  input  1  synchronous, active-high reset.
req_v_i  input  num_tiles_x_p  per-requester valid.
req_data_i  input  num_tiles_x_p*data_width_p  per-requester beat; requester x occupies slice [x].
req_yumi_o  output  num_tiles_x_p  one-hot (or zero) dequeue strobe back to the requester.
v_o  output  1  shared port valid.
data_o  output  data_width_p  shared port beat.
src_id_o  output  id_width_lp  index of the requester driving data_o.
ready_i  input  1  downstream ready; a beat transfers when v_o & ready_i.
burst_active_o  output  1  high while in BURST state.
burst_done_o  output  1  single-cycle pulse on the cycle the final beat of a burst transfers.

Behaviour:
- Registers: state_r {IDLE, BURST}, rr_ptr_r (id_width_lp), owner_r (id_width_lp), cnt_r (cnt_width_lp).
- Reset values: state_r=IDLE, rr_ptr_r=0, owner_r=0, cnt_r=0.
- Output gating during reset: while reset_i=1, v_o=0, req_yumi_o=0, burst_done_o=0 and burst_active_o=0, regardless of req_v_i.
- IDLE selection: sel = the first x with req_v_i[x]=1, scanning rr_ptr_r, rr_ptr_r+1, ... and wrapping mod num_tiles_x_p.
- IDLE outputs: v_o = |req_v_i; data_o = req_data_i[sel]; src_id_o = sel. This is combinational, so grant latency is 0 cycles.
- If no requester is valid: v_o=0, and data_o and src_id_o are don't-care.
- IDLE handshake (v_o & ready_i):
  - req_yumi_o[sel]=1.
  - If icache_block_size_in_words_p==1: burst_done_o=1, rr_ptr_r <= (sel+1) mod num_tiles_x_p, stay in IDLE.
  - Otherwise: owner_r <= sel, cnt_r <= 1, state_r <= BURST.
- IDLE without handshake: no register changes. The selection may change next cycle if the request set changes.
- BURST outputs: v_o = req_v_i[owner_r]; data_o = req_data_i[owner_r]; src_id_o = owner_r. All other requesters are ignored and their yumi is held at 0.
- BURST handshake:
  - req_yumi_o[owner_r]=1 and cnt_r <= cnt_r+1.
  - If cnt_r == icache_block_size_in_words_p-1, this is the final beat: burst_done_o=1, cnt_r <= 0, rr_ptr_r <= (owner_r+1) mod num_tiles_x_p, state_r <= IDLE.
- Owner drops valid mid-burst: the port bubbles (v_o=0) and the lock is held indefinitely. There is no timeout.
- ready_i low: no beat is accepted, and all registers and outputs stay stable while the request inputs are stable.
- Handshake rule: req_yumi_o is asserted only when v_o & ready_i. It is never asserted for a requester whose req_v_i=0.
- rr_ptr_r wrap-around: after owner num_tiles_x_p-1, the pointer becomes 0. The pointer advances only at burst completion, never on an unaccepted grant.
- num_tiles_x_p==1: id width is 1, src_id_o is always 0, and the pointer stays 0.
- Reset mid-burst: state returns to IDLE on the next edge and the partial burst is abandoned. Recovery of the partial burst is the downstream's responsibility.
- Fairness: with all requesters continuously valid, bursts are granted in order 0,1,...,n-1,0,...
- Reset_i drives only internal registers plus the output gating above; there are no other side effects.

Test Plan:
- Reset gating: reset held with all req_v_i=1 -> v_o=0 and req_yumi_o=0. First cycle after reset, with ready_i=1 -> src_id_o=0 and req_yumi_o=4'b0001.
- Round-robin order (n=4, burst=4): all valid, ready_i=1 -> 16 beats with src_id_o = 0,0,0,0,1,1,1,1,2,...,3. burst_done_o pulses on beats 4, 8, 12 and 16; the next grant is 0.
- Lock holds: requester 2 wins, then drops valid after beat 2 for 3 cycles while requesters 0 and 3 are valid -> v_o=0 for 3 cycles, no yumi to 0 or 3; the burst completes as requester 2 with 4 total beats.
- Backpressure: ready_i toggles 1,0,0,1,... during a burst -> yumi only on ready cycles, data_o stable while stalled, burst_done_o on the 4th accepted beat.
- Pointer skip and wrap: rr_ptr=3 with only requester 1 valid -> grant 1; afterwards rr_ptr=2. Pointer 3 with requester 3 completing -> rr_ptr=0.
- Reset mid-burst: assert reset_i after beat 2 of requester 1 -> next cycle state is IDLE, rr_ptr=0 and cnt=0; a new grant goes to requester 0 if it is valid.
